// File: rtl/ip_codma_bus_responder.sv
// Memory-backed codma bus responder: latency-controlled grant, 64-bit burst beats, error on illegal requests.
// Optional read-beat stall injection is enabled by defining IP_CODMA_RESP_STALL_EN.
`timescale 1ns/1ps
module ip_codma_bus_responder #(
    parameter int GRANT_LATENCY = 2,
    parameter int MEM_WORDS     = 256
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [7:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic        write_valid_i,
    input  logic [63:0] write_data_i,
    output logic        grant_o,
    output logic        read_valid_o,
    output logic [63:0] read_data_o,
    output logic        error_o,
    output logic [2:0]  state_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_INIT = (GRANT_LATENCY > 0) ? 4'(GRANT_LATENCY - 1) : 4'd0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_GRANT   = 3'd2;
    localparam logic [2:0] S_RD_BEAT = 3'd3;
    localparam logic [2:0] S_WR_BEAT = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    // Handshake: the master holds read_i/write_i until grant_o or error_o pulses; write beats
    // are consumed on any cycle with write_valid_i=1 in GRANT or WR_BEAT; read beats have no back-pressure.
    logic [2:0]    state_q, state_d;
    logic          dir_rd_q, dir_rd_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] base_q, base_d;
    logic [2:0]    beat_q, beat_d;
    logic [3:0]    wait_q, wait_d;
    logic          rvalid_q, rvalid_d;
    logic [63:0]   rdata_q, rdata_d;

    logic [31:0]   mem [MEM_WORDS];
    logic          mem_we;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_hi;
    logic [2:0]    beats;
    logic [31:0]   last_word;
    logic          illegal;
    logic          req_held;
    logic          stall;

    assign idx       = base_q + AW'({beat_q, 1'b0});
    assign idx_hi    = idx + AW'(1);
    assign beats     = 3'b001 << size_q;
    assign last_word = 32'(addr_i[31:2]) + (32'd2 << size_i[1:0]) - 32'd1;
    assign illegal   = (size_i > 8'd2) || (addr_i[2:0] != 3'd0) || (last_word >= 32'(MEM_WORDS));
    assign req_held  = dir_rd_q ? read_i : write_i;

`ifdef IP_CODMA_RESP_STALL_EN
    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; a set LSB withholds the next read beat.
    logic [7:0] lfsr_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lfsr_q <= 8'hA5;
        end else if (state_q == S_RD_BEAT) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        dir_rd_d = dir_rd_q;
        size_d   = size_q;
        base_d   = base_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read_i || write_i) begin
                    dir_rd_d = read_i;
                    size_d   = size_i[1:0];
                    base_d   = addr_i[AW+1:2];
                    beat_d   = 3'd0;
                    wait_d   = WAIT_INIT;
                    if (illegal) begin
                        state_d = S_ERR;
                    end else if (GRANT_LATENCY == 0) begin
                        state_d = S_GRANT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req_held) begin
                    state_d = S_IDLE;
                end else if (wait_q == 4'd0) begin
                    state_d = S_GRANT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_GRANT: begin
                if (dir_rd_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = {mem[idx_hi], mem[idx]};
                    beat_d   = 3'd1;
                    state_d  = S_RD_BEAT;
                end else if (write_valid_i) begin
                    mem_we  = 1'b1;
                    beat_d  = 3'd1;
                    state_d = (beats == 3'd1) ? S_IDLE : S_WR_BEAT;
                end else begin
                    state_d = S_WR_BEAT;
                end
            end
            S_RD_BEAT: begin
                if (beat_q == beats) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    rvalid_d = 1'b1;
                    rdata_d  = {mem[idx_hi], mem[idx]};
                    beat_d   = beat_q + 3'd1;
                end
            end
            S_WR_BEAT: begin
                if (write_valid_i) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if ((beat_q + 3'd1) == beats) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            dir_rd_q <= 1'b0;
            size_q   <= 2'd0;
            base_q   <= '0;
            beat_q   <= 3'd0;
            wait_q   <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 64'd0;
        end else begin
            state_q  <= state_d;
            dir_rd_q <= dir_rd_d;
            size_q   <= size_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is deliberately outside reset so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx]    <= write_data_i[31:0];
            mem[idx_hi] <= write_data_i[63:32];
        end
    end

    assign grant_o      = (state_q == S_GRANT);
    assign error_o      = (state_q == S_ERR);
    assign read_valid_o = rvalid_q;
    assign read_data_o  = rdata_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Randomized scoreboard bench for ip_codma_bus_responder against a word-array memory model.
`timescale 1ns/1ps
module tb_ip_codma_bus_responder;
    localparam int GL = 2;
    localparam int MW = 256;

    logic        clk;
    logic        reset_n;
    logic        read_i;
    logic        write_i;
    logic [7:0]  size_i;
    logic [31:0] addr_i;
    logic        write_valid_i;
    logic [63:0] write_data_i;
    logic        grant_o;
    logic        read_valid_o;
    logic [63:0] read_data_o;
    logic        error_o;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [MW];
    logic [63:0] exp_q[$];
    logic [1:0]  resp_q[$];

    ip_codma_bus_responder #(.GRANT_LATENCY(GL), .MEM_WORDS(MW)) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .read_i(read_i),
        .write_i(write_i),
        .size_i(size_i),
        .addr_i(addr_i),
        .write_valid_i(write_valid_i),
        .write_data_i(write_data_i),
        .grant_o(grant_o),
        .read_valid_o(read_valid_o),
        .read_data_o(read_data_o),
        .error_o(error_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic bit is_illegal(input logic [7:0] size, input logic [31:0] addr);
        longint last_word;
        if (size > 2) return 1'b1;
        if (addr % 8 != 0) return 1'b1;
        last_word = longint'(addr / 4) + 2 * (1 << size) - 1;
        return last_word >= MW;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_txn(input bit rd, input bit wr, input logic [7:0] size, input logic [31:0] addr,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3);
        logic [63:0] wbeat[4];
        bit err;
        bit seen;
        int beats;
        int n;
        int w;
        wbeat[0] = d0; wbeat[1] = d1; wbeat[2] = d2; wbeat[3] = d3;
        err   = is_illegal(size, addr);
        beats = err ? 1 : (1 << size);
        w     = int'(addr / 4);
        resp_q.push_back(err ? 2'b01 : 2'b10);
        if (!err && rd) begin
            for (int k = 0; k < beats; k++)
                exp_q.push_back({model_mem[w + 2*k + 1], model_mem[w + 2*k]});
        end
        @(posedge clk); #1;
        read_i = rd; write_i = wr; size_i = size; addr_i = addr;
        write_valid_i = wr; write_data_i = wbeat[0];
        n = 0; seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            seen = grant_o || error_o;
        end
        if (!seen) begin
            check("grant_or_error_timeout", 64'd0, 64'd1);
            exp_q.delete(); resp_q.delete();
        end else begin
            check(err ? "error_latency" : "grant_latency", n, err ? 2 : GL + 2);
        end
        @(posedge clk); #1;
        read_i = 1'b0; write_i = 1'b0; write_valid_i = 1'b0;
        if (seen && !err && !rd) begin
            for (int k = 1; k < beats; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                write_valid_i = 1'b1; write_data_i = wbeat[k];
                @(posedge clk); #1;
                write_valid_i = 1'b0;
            end
            for (int k = 0; k < beats; k++) begin
                model_mem[w + 2*k]     = wbeat[k][31:0];
                model_mem[w + 2*k + 1] = wbeat[k][63:32];
            end
        end
        if (seen && !err && rd) begin
`ifndef IP_CODMA_RESP_STALL_EN
            for (int k = 0; k <= beats; k++) begin
                @(negedge clk);
                check("rd_beat_shape", read_valid_o, k < beats);
            end
`endif
            n = 0;
            while (exp_q.size() != 0 && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                check("rd_beats_timeout", exp_q.size(), 0);
                exp_q.delete();
            end
        end
    endtask

    task automatic rand_txn(input bit rd, input bit wr, input logic [7:0] size, input logic [31:0] addr);
        do_txn(rd, wr, size, addr, rnd64(), rnd64(), rnd64(), rnd64());
    endtask

    // Request withdrawn while waiting for the grant: nothing is expected.
    task automatic drop_txn(input bit rd);
        @(posedge clk); #1;
        read_i = rd; write_i = !rd; write_valid_i = !rd;
        size_i = 8'd0; addr_i = 32'h8; write_data_i = rnd64();
        @(posedge clk); #1;
        read_i = 1'b0; write_i = 1'b0; write_valid_i = 1'b0;
        repeat (GL + 4) @(posedge clk);
    endtask

    task automatic reset_mid_write(input logic [31:0] addr);
        logic [63:0] b0;
        logic [63:0] b1;
        int w;
        int n;
        bit seen;
        b0 = rnd64(); b1 = rnd64(); w = int'(addr / 4);
        resp_q.push_back(2'b10);
        @(posedge clk); #1;
        read_i = 1'b0; write_i = 1'b1; size_i = 8'd2; addr_i = addr;
        write_valid_i = 1'b1; write_data_i = b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            seen = grant_o;
        end
        check("rst_burst_grant_seen", seen, 1'b1);
        @(posedge clk); #1;
        write_i = 1'b0; write_data_i = b1;
        @(posedge clk); #1;
        reset_n = 1'b0; write_valid_i = 1'b0;
        #1;
        check("rst_grant_o", grant_o, 1'b0);
        check("rst_error_o", error_o, 1'b0);
        check("rst_read_valid_o", read_valid_o, 1'b0);
        check("rst_read_data_o", read_data_o, 64'd0);
        model_mem[w]     = b0[31:0];
        model_mem[w + 1] = b0[63:32];
        model_mem[w + 2] = b1[31:0];
        model_mem[w + 3] = b1[63:32];
        resp_q.delete();
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [63:0] mon_exp;
    logic [1:0]  mon_resp;
    always @(negedge clk) begin
        if (reset_n) begin
            if (grant_o || error_o) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", {grant_o, error_o}, 2'b00);
                end else begin
                    mon_resp = resp_q.pop_front();
                    check("resp_kind", {grant_o, error_o}, mon_resp);
                end
            end
            if (read_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", read_valid_o, 1'b0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rd_data", read_data_o, mon_exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int kind;
    int sz;
    int beats;
    logic [31:0] addr;
    bit rd;
    bit wr;

    initial begin
        reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0; size_i = 8'd0; addr_i = 32'd0;
        write_valid_i = 1'b0; write_data_i = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_grant_o", grant_o, 1'b0);
        check("reset_error_o", error_o, 1'b0);
        check("reset_read_valid_o", read_valid_o, 1'b0);
        check("reset_read_data_o", read_data_o, 64'd0);
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < MW / 8; i++) rand_txn(1'b0, 1'b1, 8'd2, 32'(i * 32));

        do_txn(1'b0, 1'b1, 8'd1, 32'h20, 64'h1111_1111_0000_0000, 64'h3333_3333_2222_2222, 64'd0, 64'd0);
        rand_txn(1'b1, 1'b0, 8'd1, 32'h20);

        rand_txn(1'b1, 1'b1, 8'd0, 32'h0);
        rand_txn(1'b1, 1'b0, 8'd0, 32'h0);

        rand_txn(1'b1, 1'b0, 8'd9, 32'h40);
        rand_txn(1'b0, 1'b1, 8'd0, 32'h4);
        rand_txn(1'b0, 1'b1, 8'd2, 32'h7F8);
        rand_txn(1'b1, 1'b0, 8'd2, 32'h7F8);

        drop_txn(1'b1);
        drop_txn(1'b0);
        rand_txn(1'b1, 1'b0, 8'd0, 32'h8);

        rand_txn(1'b1, 1'b0, 8'd2, 32'h100);
        reset_mid_write(32'h100);
        rand_txn(1'b1, 1'b0, 8'd2, 32'h100);

        for (int i = 0; i < 100; i++) begin
            kind  = $urandom_range(0, 9);
            sz    = $urandom_range(0, 2);
            beats = 1 << sz;
            addr  = 32'($urandom_range(0, (MW - 2 * beats) / 2) * 8);
            rd    = $urandom_range(0, 1) == 1;
            wr    = !rd || ($urandom_range(0, 3) == 0);
            if (kind == 0) sz = $urandom_range(3, 255);
            if (kind == 1) addr = addr | 32'($urandom_range(1, 7));
            if (kind == 2) addr = ($urandom() | 32'h400) & ~32'h7;
            rand_txn(rd, wr, 8'(sz), addr);
        end

        for (int i = 0; i < MW / 8; i++) rand_txn(1'b1, 1'b0, 8'd2, 32'(i * 32));

        repeat (4) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
